data_mem_responder: RTL and testbench

Multi-cycle data-memory responder serving load/store requests from the MEM stage of the five-stage pipeline. It accepts one word access at a time, holds the pipeline with `freeze` for a fixed number of cycles, then commits the access and pulses `ready`. It is the memory-side counterpart to the MEM stage's request outputs, in the same way the instruction memory answers the IF stage.

---
 rtl/data_mem_if.sv | 23 ++
 rtl/data_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM pipeline stage and the data-memory
// responder. The MEM stage drives the request side; the responder drives the
// completion side and the pipeline hold.
interface data_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        freeze;
  logic        misaligned;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, ready, freeze, misaligned
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, ready, freeze, misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder. One word access is accepted at a time,
// the pipeline is held with freeze for LATENCY cycles, then the access commits
// and ready pulses for one cycle. Misaligned accesses never store and load a
// fixed poison word.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 3
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int ADR_W = IDX_W + 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0] POISON_WORD   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Misalignment test on the byte offset of a word access.
  function automatic logic is_misaligned(input logic [ADR_W-1:0] a);
    return (a[1:0] != 2'b00);
  endfunction

  // Word index; upper address bits are dropped so accesses wrap.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADR_W-1:0] a);
    return a[ADR_W-1:2];
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;

  logic [ADR_W-1:0]  addr_r;
  logic [31:0]       wdata_r;
  logic              is_write_r;

  logic [31:0]       mem_r [DEPTH];
  logic [31:0]       read_data_r;
  logic              ready_r;
  logic              misaligned_r;

  logic              req_s;
  logic              accept_s;
  logic              commit_s;
  logic [ADR_W-1:0]  acc_addr_s;
  logic [31:0]       acc_wdata_s;
  logic              acc_write_s;
  logic              acc_misaligned_s;
  logic [IDX_W-1:0]  acc_idx_s;

  assign req_s = bus.mem_read | bus.mem_write;

  // Next-state and countdown logic for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          accept_s     = 1'b1;
          cnt_next_s   = CNT_LOAD;
          state_next_s = (LATENCY > 1) ? BUSY : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        cnt_next_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Access operands: live bus values when committing straight out of IDLE
  // (single-cycle latency), otherwise the values latched at acceptance.
  always_comb begin
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_write_s = is_write_r;
    if (state_r == IDLE) begin
      acc_addr_s  = bus.address[ADR_W-1:0];
      acc_wdata_s = bus.write_data;
      acc_write_s = bus.mem_write;
    end else begin
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_write_s = is_write_r;
    end
  end

  assign acc_misaligned_s = is_misaligned(acc_addr_s);
  assign acc_idx_s        = word_index(acc_addr_s);
  assign commit_s         = (state_r != DONE) && (state_next_s == DONE);

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Capture the request on acceptance; a store wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r     <= '0;
      wdata_r    <= 32'h0000_0000;
      is_write_r <= 1'b0;
    end else if (accept_s) begin
      addr_r     <= bus.address[ADR_W-1:0];
      wdata_r    <= bus.write_data;
      is_write_r <= bus.mem_write;
    end
  end

  // Word storage: cleared by reset, written by an aligned store on commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (commit_s && acc_write_s && !acc_misaligned_s) begin
      mem_r[acc_idx_s] <= acc_wdata_s;
    end
  end

  // Completion outputs; read_data only moves on a completed load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      read_data_r  <= 32'h0000_0000;
      ready_r      <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      ready_r      <= commit_s;
      misaligned_r <= commit_s & acc_misaligned_s;
      if (commit_s && !acc_write_s) begin
        read_data_r <= acc_misaligned_s ? POISON_WORD : mem_r[acc_idx_s];
      end
    end
  end

  assign bus.read_data  = read_data_r;
  assign bus.ready      = ready_r;
  assign bus.misaligned = misaligned_r;
  assign bus.freeze     = ((state_r == IDLE) & req_s) | (state_r == BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a timeline model of each access (cycles
// elapsed since acceptance, word array, last load result) is compared with
// the DUT every cycle, plus directed literal checks and a LATENCY=1 instance.
module tb_data_mem_responder;
  localparam int LAT = 3;
  localparam int DEP = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_if bus ();
  data_mem_if bus1 ();

  data_mem_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  data_mem_responder #(.DEPTH(DEP), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEP];
  logic [31:0] m_rdata;
  logic        m_mis;
  logic        m_valid = 1'b0;
  int          m_age   = -1;   // -1: idle, else cycles since acceptance
  int          prev_age;
  logic        m_wr;
  logic [31:0] m_addr, m_wd;
  logic        m_req;
  logic        e_freeze, e_ready, e_mis;
  int          m_idx;

  // Every cycle: compare against the model, then advance the model one cycle.
  always @(negedge clk) begin
    m_req = bus.mem_read | bus.mem_write;
    if (m_valid) begin
      if (m_age < 0) begin
        e_freeze = m_req; e_ready = 1'b0; e_mis = 1'b0;
      end else if (m_age < LAT) begin
        e_freeze = 1'b1; e_ready = 1'b0; e_mis = 1'b0;
      end else begin
        e_freeze = 1'b0; e_ready = 1'b1; e_mis = m_mis;
      end
      check("freeze", {31'd0, bus.freeze}, {31'd0, e_freeze});
      check("ready", {31'd0, bus.ready}, {31'd0, e_ready});
      check("misaligned", {31'd0, bus.misaligned}, {31'd0, e_mis});
      check("read_data", bus.read_data, m_rdata);
    end
    if (!rst) begin
      m_valid = 1'b1;
      m_age   = -1;
      m_rdata = 32'h0;
      m_mis   = 1'b0;
      for (int i = 0; i < DEP; i++) m_mem[i] = 32'h0;
    end else if (m_valid) begin
      prev_age = m_age;
      if (m_age < 0) begin
        if (m_req) begin
          m_wr   = bus.mem_write;
          m_addr = bus.address;
          m_wd   = bus.write_data;
          m_age  = 1;
        end
      end else if (m_age < LAT) begin
        m_age = m_age + 1;
      end else begin
        m_age = -1;
      end
      if (m_age == LAT && prev_age != LAT) begin
        m_idx = int'((m_addr >> 2) % DEP);
        m_mis = (m_addr % 4) != 0;
        if (m_wr) begin
          if (!m_mis) m_mem[m_idx] = m_wd;
        end else begin
          m_rdata = m_mis ? 32'hDEADBEEF : m_mem[m_idx];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Issue one access (called just after a rising edge); returns the completion
  // outputs and the number of frozen cycles seen before ready.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output logic mis, output int fcnt);
    bit seen;
    seen = 1'b0;
    fcnt = 0;
    rdata = 32'h0;
    mis = 1'b0;
    bus.mem_read = rd; bus.mem_write = wr; bus.address = a; bus.write_data = d;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        seen = 1'b1;
        rdata = bus.read_data;
        mis = bus.misaligned;
      end else if (bus.freeze === 1'b1) begin
        fcnt++;
      end
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  logic [31:0] rd_v, addr_v;
  logic        mis_v, r_rd, r_wr;
  int          fc;

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.address = 32'h0; bus1.write_data = 32'h0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_misaligned", {31'd0, bus.misaligned}, 32'd0);
    check("rst_freeze", {31'd0, bus.freeze}, 32'd0);
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'h10, 32'h0, rd_v, mis_v, fc);
    check("load_after_reset", rd_v, 32'h0);

    access(1'b0, 1'b1, 32'h8, 32'h12345678, rd_v, mis_v, fc);
    check("store_freeze_cycles", 32'(fc), 32'd3);
    access(1'b1, 1'b0, 32'h8, 32'h0, rd_v, mis_v, fc);
    check("load_freeze_cycles", 32'(fc), 32'd3);
    check("load_0x8", rd_v, 32'h12345678);

    access(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, rd_v, mis_v, fc);
    access(1'b1, 1'b0, 32'h0, 32'h0, rd_v, mis_v, fc);
    check("wrap_load_0x0", rd_v, 32'hCAFEF00D);

    access(1'b1, 1'b1, 32'h4, 32'h1, rd_v, mis_v, fc);
    check("both_keeps_read_data", rd_v, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h4, 32'h0, rd_v, mis_v, fc);
    check("priority_load_0x4", rd_v, 32'h1);

    access(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, rd_v, mis_v, fc);
    check("mis_store_flag", {31'd0, mis_v}, 32'd1);
    access(1'b1, 1'b0, 32'h6, 32'h0, rd_v, mis_v, fc);
    check("mis_load_flag", {31'd0, mis_v}, 32'd1);
    check("mis_load_data", rd_v, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h4, 32'h0, rd_v, mis_v, fc);
    check("load_0x4_intact", rd_v, 32'h1);
    check("aligned_flag_clear", {31'd0, mis_v}, 32'd0);

    // Reset during the second BUSY cycle of a store.
    bus.mem_write = 1'b1; bus.address = 32'hC; bus.write_data = 32'hAAAA5555;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; bus.mem_write = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_freeze", {31'd0, bus.freeze}, 32'd0);
    check("abort_ready", {31'd0, bus.ready}, 32'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'hC, 32'h0, rd_v, mis_v, fc);
    check("abort_no_store", rd_v, 32'h0);

    // Randomized traffic, including back-to-back and dual requests.
    for (int n = 0; n < 150; n++) begin
      addr_v = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFF00) : 32'h0;
      addr_v = addr_v | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) addr_v = addr_v | 32'($urandom_range(1, 3));
      r_wr = ($urandom_range(0, 2) == 0);
      r_rd = !r_wr || ($urandom_range(0, 3) == 0);
      access(r_rd, r_wr, addr_v, $urandom, rd_v, mis_v, fc);
      check("rand_freeze_cycles", 32'(fc), 32'(LAT));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // LATENCY = 1 instance: IDLE -> DONE -> IDLE.
    bus1.mem_write = 1'b1; bus1.address = 32'h8; bus1.write_data = 32'h0BADF00D;
    @(negedge clk);
    check("l1_store_freeze", {31'd0, bus1.freeze}, 32'd1);
    check("l1_store_ready_early", {31'd0, bus1.ready}, 32'd0);
    @(posedge clk); #1 bus1.mem_write = 1'b0;
    @(negedge clk);
    check("l1_store_ready", {31'd0, bus1.ready}, 32'd1);
    check("l1_store_done_freeze", {31'd0, bus1.freeze}, 32'd0);
    @(posedge clk); #1 bus1.mem_read = 1'b1; bus1.address = 32'h8;
    @(negedge clk);
    check("l1_load_freeze", {31'd0, bus1.freeze}, 32'd1);
    check("l1_load_ready_early", {31'd0, bus1.ready}, 32'd0);
    @(posedge clk); #1 bus1.mem_read = 1'b0;
    @(negedge clk);
    check("l1_load_ready", {31'd0, bus1.ready}, 32'd1);
    check("l1_load_data", bus1.read_data, 32'h0BADF00D);
    check("l1_load_done_freeze", {31'd0, bus1.freeze}, 32'd0);
    @(negedge clk);
    check("l1_idle_ready", {31'd0, bus1.ready}, 32'd0);
    check("l1_idle_freeze", {31'd0, bus1.freeze}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
